// File: rtl/adder_tree_sched_if.sv
// Requester and result handshakes for the shared adder-tree scheduler.
// master = requesters/consumer side, slave = scheduler side.
interface adder_tree_sched_if #(
  parameter int NUM   = 18,
  parameter int LEN   = 16,
  parameter int LEVEL = 5,
  parameter int REQ   = 4
);
  localparam int IW = (REQ > 1) ? $clog2(REQ) : 1;

  logic [REQ-1:0]         req_valid;
  logic [REQ*NUM*LEN-1:0] req_data;
  logic [REQ-1:0]         req_ready;
  logic                   res_valid;
  logic                   res_ready;
  logic [IW-1:0]          res_id;
  logic [LEN+LEVEL-1:0]   res_sum;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_sum
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_sum
  );
endinterface

// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one pipelined adder tree between
// requesters, with tag realignment and a credit-guarded result FIFO.
module adder_tree_sched #(
  parameter int NUM       = 18,
  parameter int LEN       = 16,
  parameter int LEVEL     = 5,
  parameter int LAT       = 5,
  parameter int REQ       = 4,
  parameter int RES_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_tree_sched_if.slave    bus,
  output logic [NUM*LEN-1:0]   tree_in,
  input  logic [LEN+LEVEL-1:0] tree_sum,
  output logic                 busy
);
  localparam int IW = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int SW = LEN + LEVEL;
  localparam int VW = NUM * LEN;
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int OW = $clog2(LAT + RES_DEPTH + 1);

  logic [IW-1:0]  ptr;
  logic [IW-1:0]  sel;
  logic [IW-1:0]  cand;
  logic           issue;
  logic           can_issue;
  logic [OW-1:0]  outstanding;

  logic [LAT-1:0] tag_v;
  logic [IW-1:0]  tag_id [LAT];

  logic [SW-1:0]  sum_mem [RES_DEPTH];
  logic [IW-1:0]  id_mem  [RES_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;

  // Credits cover every issue not yet popped, so a push never overflows.
  always_comb begin
    outstanding = OW'(count);
    for (int i = 0; i < LAT; i++)
      outstanding = outstanding + OW'(tag_v[i]);
  end

  assign can_issue = rst_n && (outstanding < OW'(RES_DEPTH));

  always_comb begin
    issue = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < REQ; i++) begin
      cand = IW'((int'(ptr) + i) % REQ);
      if (!issue && can_issue && bus.req_valid[cand]) begin
        issue = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (issue)
      bus.req_ready[sel] = 1'b1;
  end

  assign push = tag_v[LAT-1];
  assign pop  = bus.res_valid & bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_in <= '0;
      ptr     <= '0;
      tag_v   <= '0;
      for (int i = 0; i < LAT; i++)
        tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= sel;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      if (issue) begin
        tree_in <= bus.req_data[int'(sel)*VW +: VW];
        ptr     <= (sel == IW'(REQ - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(RES_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(RES_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sum_mem[wr_ptr] <= tree_sum;
      id_mem[wr_ptr]  <= tag_id[LAT-1];
    end
  end

  assign bus.res_valid = (count != '0);
  assign bus.res_id    = id_mem[rd_ptr];
  assign bus.res_sum   = sum_mem[rd_ptr];
  assign busy          = (|tag_v) | bus.res_valid;
endmodule
